// File: rtl/eq_checker_pkg.sv
// Shared types and default widths for the registered masked equality checker.
package eq_checker_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam int EQ_WIDTH_DEF = 8;
  localparam int EQ_CNT_W_DEF = 16;

endpackage

// File: rtl/sat_counter.sv
// Event counter that saturates at all-ones; clr wins over inc.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] q_reg;
  logic [W-1:0] q_next;

  always_comb begin
    q_next = q_reg;
    if (clr) begin
      q_next = '0;
    end else if (inc && (q_reg != {W{1'b1}})) begin
      q_next = q_reg + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= '0;
    end else begin
      q_reg <= q_next;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/eq_checker.sv
// Masked bitwise equality checker with a one-deep valid/ready result register,
// saturating match/mismatch counters and a sticky error flag.
module eq_checker
  import eq_checker_pkg::*;
#(
  parameter int WIDTH = EQ_WIDTH_DEF,
  parameter int CNT_W = EQ_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] eq_bits,
  output logic             eq,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             err_sticky
);

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] eq_bits_reg;
  logic             eq_reg;
  logic             err_reg;
  logic             accept;
  logic [WIDTH-1:0] r_bits;
  logic             r_eq;

  // Don't-care bits are forced to 1 so they never break the word match.
  assign r_bits = ~(a ^ b) | ~mask;
  assign r_eq   = &r_bits;
  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_EMPTY: if (accept) state_next = ST_FULL;
      ST_FULL:  if (out_ready && !accept) state_next = ST_EMPTY;
      default:  state_next = ST_EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state_reg == ST_FULL);
    in_ready  = (state_reg == ST_EMPTY) || out_ready;
  end

  // Result payload only moves on accept; it holds its last value once drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eq_bits_reg <= '0;
      eq_reg      <= 1'b0;
    end else if (accept) begin
      eq_bits_reg <= r_bits;
      eq_reg      <= r_eq;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else if (clr) begin
      err_reg <= 1'b0;
    end else if (accept && !r_eq) begin
      err_reg <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept && r_eq),
    .clr   (clr),
    .q     (match_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mismatch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept && !r_eq),
    .clr   (clr),
    .q     (mismatch_cnt)
  );

  assign eq_bits    = eq_bits_reg;
  assign eq         = eq_reg;
  assign err_sticky = err_reg;

endmodule

// File: tb/tb_eq_checker.sv
// Scoreboard bench for eq_checker: results queued on accept, popped on drain.
module tb_eq_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a, b, mask;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  eq_bits;
  logic        eq;
  logic [15:0] match_cnt, mismatch_cnt;
  logic        err_sticky;

  logic        s_clr, s_valid, s_in_ready, s_out_valid, s_eq, s_err;
  logic [7:0]  s_a, s_b, s_mask, s_eq_bits;
  logic [1:0]  s_match, s_mismatch;

  int checks = 0;
  int failures = 0;
  int results_seen = 0;
  logic [8:0]  sb_q[$];
  logic [15:0] exp_match, exp_mismatch;
  logic        exp_err;

  always #5 clk = ~clk;

  eq_checker #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mask(mask), .out_valid(out_valid), .out_ready(out_ready),
    .eq_bits(eq_bits), .eq(eq), .match_cnt(match_cnt), .mismatch_cnt(mismatch_cnt),
    .err_sticky(err_sticky)
  );

  eq_checker #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .clr(s_clr), .in_valid(s_valid), .in_ready(s_in_ready),
    .a(s_a), .b(s_b), .mask(s_mask), .out_valid(s_out_valid), .out_ready(1'b1),
    .eq_bits(s_eq_bits), .eq(s_eq), .match_cnt(s_match), .mismatch_cnt(s_mismatch),
    .err_sticky(s_err)
  );

  // Drain monitor: a transfer happens at the next rising edge when both are high.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      logic [8:0] exp_r;
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_underflow: got eq_bits=%h eq=%b, required no result", eq_bits, eq);
      end else begin
        exp_r = sb_q.pop_front();
        results_seen++;
        if ({eq_bits, eq} !== exp_r) begin
          failures++;
          $display("FAIL sb_result: got eq_bits=%h eq=%b, required eq_bits=%h eq=%b",
                   eq_bits, eq, exp_r[8:1], exp_r[0]);
        end
      end
    end
  end

  task automatic push_pair(input logic [7:0] pa, input logic [7:0] pb,
                           input logic [7:0] pm, input logic pclr);
    logic [7:0] rb;
    logic       re;
    bit         done = 0;
    a = pa; b = pb; mask = pm; in_valid = 1'b1; clr = pclr;
    rb = ~(pa ^ pb) | ~pm;
    re = &rb;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back({rb, re});
        if (pclr) begin
          exp_match = '0; exp_mismatch = '0; exp_err = 1'b0;
        end else if (re) begin
          if (exp_match != 16'hFFFF) exp_match++;
        end else begin
          if (exp_mismatch != 16'hFFFF) exp_mismatch++;
          exp_err = 1'b1;
        end
        @(posedge clk); #1;
        done = 1;
      end
    end
    clr = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL accept_timeout: got in_ready=0 for 50 cycles, required 1");
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    checks++;
    if ({out_valid, eq_bits, eq, match_cnt, mismatch_cnt, err_sticky} !== '0) begin
      failures++;
      $display("FAIL reset_state: got ov=%b eqb=%h eq=%b m=%0d mm=%0d err=%b, required all 0",
               out_valid, eq_bits, eq, match_cnt, mismatch_cnt, err_sticky);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_equal();
    out_ready = 1'b1;
    push_pair(8'hA5, 8'hA5, 8'hFF, 1'b0);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || eq_bits !== 8'hFF || eq !== 1'b1 || match_cnt !== 16'd1) begin
      failures++;
      $display("FAIL equal_full: got ov=%b eqb=%h eq=%b m=%0d, required 1 ff 1 1",
               out_valid, eq_bits, eq, match_cnt);
    end
    push_pair(8'hA5, 8'h25, 8'h7F, 1'b0);
    in_valid = 1'b0;
    checks++;
    if (eq_bits !== 8'hFF || eq !== 1'b1 || match_cnt !== 16'd2) begin
      failures++;
      $display("FAIL equal_masked: got eqb=%h eq=%b m=%0d, required ff 1 2", eq_bits, eq, match_cnt);
    end
    idle(2);
    checks++;
    if (out_valid !== 1'b0 || eq_bits !== 8'hFF) begin
      failures++;
      $display("FAIL drain_hold: got ov=%b eqb=%h, required 0 ff", out_valid, eq_bits);
    end
  endtask

  task automatic test_mismatch();
    push_pair(8'h0F, 8'h0E, 8'hFF, 1'b0);
    in_valid = 1'b0;
    checks++;
    if (eq_bits !== 8'hFE || eq !== 1'b0 || mismatch_cnt !== 16'd1 || err_sticky !== 1'b1) begin
      failures++;
      $display("FAIL mismatch: got eqb=%h eq=%b mm=%0d err=%b, required fe 0 1 1",
               eq_bits, eq, mismatch_cnt, err_sticky);
    end
    push_pair(8'h33, 8'h33, 8'hFF, 1'b0);
    push_pair(8'h00, 8'hFF, 8'h00, 1'b0);
    in_valid = 1'b0;
    checks++;
    if (err_sticky !== 1'b1 || match_cnt !== exp_match || eq !== 1'b1) begin
      failures++;
      $display("FAIL err_hold: got err=%b m=%0d eq=%b, required 1 %0d 1",
               err_sticky, match_cnt, eq, exp_match);
    end
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    exp_match = '0; exp_mismatch = '0; exp_err = 1'b0;
    checks++;
    if (match_cnt !== 16'd0 || mismatch_cnt !== 16'd0 || err_sticky !== 1'b0) begin
      failures++;
      $display("FAIL clr: got m=%0d mm=%0d err=%b, required 0 0 0", match_cnt, mismatch_cnt, err_sticky);
    end
    idle(2);
  endtask

  task automatic test_backpressure();
    int seen0;
    int cnt0;
    out_ready = 1'b0;
    push_pair(8'h11, 8'h11, 8'hFF, 1'b0);
    a = 8'h22; b = 8'h23; mask = 8'hFF; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || eq_bits !== 8'hFF) begin
        failures++;
        $display("FAIL stall_%0d: got rdy=%b ov=%b eqb=%h, required 0 1 ff", i, in_ready, out_valid, eq_bits);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    push_pair(8'h22, 8'h23, 8'hFF, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || eq_bits !== 8'hFE || eq !== 1'b0) begin
      failures++;
      $display("FAIL no_bubble: got ov=%b eqb=%h eq=%b, required 1 fe 0", out_valid, eq_bits, eq);
    end
    idle(2);
    seen0 = results_seen;
    cnt0  = int'(match_cnt) + int'(mismatch_cnt);
    push_pair(8'h01, 8'h01, 8'hFF, 1'b0);
    push_pair(8'h02, 8'h03, 8'hFF, 1'b0);
    push_pair(8'hC4, 8'h44, 8'h7F, 1'b0);
    push_pair(8'h80, 8'h00, 8'hF0, 1'b0);
    idle(3);
    checks++;
    if (results_seen - seen0 != 4 || int'(match_cnt) + int'(mismatch_cnt) - cnt0 != 4) begin
      failures++;
      $display("FAIL b2b_count: got results=%0d counts=%0d, required 4 4",
               results_seen - seen0, int'(match_cnt) + int'(mismatch_cnt) - cnt0);
    end
    checks++;
    if (match_cnt !== exp_match || mismatch_cnt !== exp_mismatch || err_sticky !== exp_err) begin
      failures++;
      $display("FAIL b2b_model: got m=%0d mm=%0d err=%b, required %0d %0d %b",
               match_cnt, mismatch_cnt, err_sticky, exp_match, exp_mismatch, exp_err);
    end
  endtask

  task automatic test_clr_accept();
    out_ready = 1'b1;
    push_pair(8'h0F, 8'h00, 8'hFF, 1'b1);
    in_valid = 1'b0;
    checks++;
    if (match_cnt !== 16'd0 || mismatch_cnt !== 16'd0 || err_sticky !== 1'b0 ||
        eq !== 1'b0 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL clr_accept: got m=%0d mm=%0d err=%b eq=%b ov=%b, required 0 0 0 0 1",
               match_cnt, mismatch_cnt, err_sticky, eq, out_valid);
    end
    idle(2);
  endtask

  task automatic test_saturation();
    s_a = 8'h5A; s_b = 8'h5A; s_mask = 8'hFF; s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        checks++;
        if (s_match !== 2'd1) begin
          failures++;
          $display("FAIL sat_first: got %0d required 1", s_match);
        end
      end
    end
    s_valid = 1'b0;
    checks++;
    if (s_match !== 2'd3 || s_mismatch !== 2'd0) begin
      failures++;
      $display("FAIL sat_5: got m=%0d mm=%0d required 3 0", s_match, s_mismatch);
    end
    @(posedge clk); #1;
    checks++;
    if (s_match !== 2'd3) begin
      failures++;
      $display("FAIL sat_hold: got %0d required 3", s_match);
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    push_pair(8'h44, 8'h45, 8'hFF, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    sb_q.delete();
    exp_match = '0; exp_mismatch = '0; exp_err = 1'b0;
    #2;
    checks++;
    if ({out_valid, eq_bits, eq, match_cnt, mismatch_cnt, err_sticky} !== '0 || s_match !== 2'd0) begin
      failures++;
      $display("FAIL reset_mid: got ov=%b eqb=%h eq=%b m=%0d mm=%0d err=%b sm=%0d, required all 0",
               out_valid, eq_bits, eq, match_cnt, mismatch_cnt, err_sticky, s_match);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(2);
  endtask

  initial begin
    clr = 1'b0; in_valid = 1'b0; a = '0; b = '0; mask = '0; out_ready = 1'b0;
    s_clr = 1'b0; s_valid = 1'b0; s_a = '0; s_b = '0; s_mask = '0;
    exp_match = '0; exp_mismatch = '0; exp_err = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_equal();
    test_mismatch();
    test_backpressure();
    test_clr_accept();
    test_saturation();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
